// File: rtl/dmem_arbiter.sv
// Byte-serial data-memory controller: round-robin between core load/store port and host
// byte loader, splitting multi-byte core accesses into little-endian single-byte RAM cycles.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | waiting for a request; grants core or loader
//   S_CPU_WR | issuing core store bytes 0..N-1 to the RAM
//   S_CPU_RD | issuing core load addresses and capturing returned bytes
//   S_LD_WR  | loader byte on RAM outputs, written at the next edge
//   S_DONE   | one-cycle completion pulse to the core
module dmem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_write,
    input  logic              i_cpu_load,
    input  logic [31:0]       i_cpu_addr,
    input  logic [31:0]       i_cpu_wdata,
    input  logic [1:0]        i_cpu_size,
    output logic [31:0]       o_cpu_rdata,
    output logic              o_cpu_done,
    output logic              o_cpu_stall,
    input  logic              i_ld_valid,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [7:0]        i_ld_wdata,
    output logic              o_ld_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    input  logic [7:0]        i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CPU_WR = 3'd1,
        S_CPU_RD = 3'd2,
        S_LD_WR  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic              last_ld;
    logic              cpu_req, grant_cpu, grant_ld;
    logic [2:0]        req_n, n_q, cnt_q;
    logic [31:0]       keep_mask, wdata_q;
    logic [ADDR_W-1:0] base_q, addr_nxt;
    logic [1:0]        lane_nxt, lane_cap;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^i_cpu_addr[31:ADDR_W];
    assign cpu_req  = i_cpu_write | i_cpu_load;
    assign addr_nxt = base_q + ADDR_W'(cnt_q + 3'd1);
    assign lane_nxt = cnt_q[1:0] + 2'd1;
    // cnt_q runs one cycle ahead of the returning read byte
    assign lane_cap = cnt_q[1:0] - 2'd1;

    always_comb begin
        req_n     = 3'd0;
        keep_mask = 32'h0000_0000;
        case (i_cpu_size)
            2'b01: begin req_n = 3'd1; keep_mask = 32'h0000_00FF; end
            2'b10: begin req_n = 3'd2; keep_mask = 32'h0000_FFFF; end
            2'b11: begin req_n = 3'd4; keep_mask = 32'hFFFF_FFFF; end
            default: ;
        endcase
    end

    always_comb begin
        grant_cpu = 1'b0;
        grant_ld  = 1'b0;
        if (state == S_IDLE) begin
            if (cpu_req && i_ld_valid) begin
                grant_cpu = last_ld;
                grant_ld  = ~last_ld;
            end else begin
                grant_cpu = cpu_req;
                grant_ld  = i_ld_valid;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (grant_cpu) begin
                    if (req_n == 3'd0)    state_nxt = S_DONE;
                    else if (i_cpu_write) state_nxt = S_CPU_WR;
                    else                  state_nxt = S_CPU_RD;
                end else if (grant_ld) begin
                    state_nxt = S_LD_WR;
                end
            end
            S_CPU_WR: if (cnt_q == n_q - 3'd1) state_nxt = S_DONE;
            S_CPU_RD: if (cnt_q == n_q)        state_nxt = S_DONE;
            S_LD_WR:  state_nxt = S_IDLE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_cpu_done = (state == S_DONE);
        o_ld_ready = grant_ld;
    end

    assign o_cpu_stall = cpu_req & ~o_cpu_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= 8'h00;
            o_cpu_rdata <= 32'h0000_0000;
            last_ld     <= 1'b1;
            base_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            n_q         <= 3'd0;
            cnt_q       <= 3'd0;
        end else begin
            o_mem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_cpu) begin
                        last_ld <= 1'b0;
                        base_q  <= i_cpu_addr[ADDR_W-1:0];
                        wdata_q <= i_cpu_wdata;
                        n_q     <= req_n;
                        cnt_q   <= 3'd0;
                        if (req_n != 3'd0) begin
                            o_mem_addr <= i_cpu_addr[ADDR_W-1:0];
                            if (i_cpu_write) begin
                                o_mem_we    <= 1'b1;
                                o_mem_wdata <= i_cpu_wdata[7:0];
                            end else begin
                                o_cpu_rdata <= o_cpu_rdata & keep_mask;
                            end
                        end
                    end else if (grant_ld) begin
                        last_ld     <= 1'b1;
                        o_mem_addr  <= i_ld_addr;
                        o_mem_we    <= 1'b1;
                        o_mem_wdata <= i_ld_wdata;
                    end
                end
                S_CPU_WR: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q != n_q - 3'd1) begin
                        o_mem_addr  <= addr_nxt;
                        o_mem_we    <= 1'b1;
                        o_mem_wdata <= wdata_q[{lane_nxt, 3'b000} +: 8];
                    end
                end
                S_CPU_RD: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q + 3'd1 < n_q) o_mem_addr <= addr_nxt;
                    if (cnt_q != 3'd0) o_cpu_rdata[{lane_cap, 3'b000} +: 8] <= i_mem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: byte-wide sync RAM model, expected core results queued
// at stimulus time and retired when the controller pulses done.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;

    logic              i_clk = 1'b0;
    logic              i_rst_n;
    logic              i_cpu_write, i_cpu_load;
    logic [31:0]       i_cpu_addr, i_cpu_wdata;
    logic [1:0]        i_cpu_size;
    logic [31:0]       o_cpu_rdata;
    logic              o_cpu_done, o_cpu_stall;
    logic              i_ld_valid;
    logic [ADDR_W-1:0] i_ld_addr;
    logic [7:0]        i_ld_wdata;
    logic              o_ld_ready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_we;
    logic [7:0]        o_mem_wdata;
    logic [7:0]        i_mem_rdata;

    logic [7:0] ram [0:255];
    logic       ram_init;

    typedef struct {
        logic        chk_rdata;
        logic [31:0] rdata;
        int          stall;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   stall_cnt = 0;
    int   we_cnt = 0;
    int   done_cnt = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_cpu_write (i_cpu_write),
        .i_cpu_load  (i_cpu_load),
        .i_cpu_addr  (i_cpu_addr),
        .i_cpu_wdata (i_cpu_wdata),
        .i_cpu_size  (i_cpu_size),
        .o_cpu_rdata (o_cpu_rdata),
        .o_cpu_done  (o_cpu_done),
        .o_cpu_stall (o_cpu_stall),
        .i_ld_valid  (i_ld_valid),
        .i_ld_addr   (i_ld_addr),
        .i_ld_wdata  (i_ld_wdata),
        .o_ld_ready  (o_ld_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_we    (o_mem_we),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hA5;
        end else if (o_mem_we) begin
            ram[o_mem_addr] <= o_mem_wdata;
        end
        i_mem_rdata <= ram[o_mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Retire one expected access per done pulse
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            stall_cnt = 0;
        end else begin
            if (o_mem_we) we_cnt++;
            if (o_cpu_stall) stall_cnt++;
            if (o_cpu_done) begin
                exp_t e;
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check_eq("sb_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    if (e.chk_rdata) check_eq("cpu_rdata", o_cpu_rdata, e.rdata);
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic cpu_access(input logic wr, input logic ld, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size,
                              input logic [31:0] exp_rd);
        exp_t e;
        int   n;
        bit   seen;
        n = (size == 2'b01) ? 1 : (size == 2'b10) ? 2 : (size == 2'b11) ? 4 : 0;
        e.chk_rdata = !wr;
        e.rdata     = exp_rd;
        e.stall     = (n == 0) ? 1 : (wr ? n + 1 : n + 2);
        sb_q.push_back(e);
        @(posedge i_clk); #1;
        i_cpu_write = wr; i_cpu_load = ld; i_cpu_addr = addr;
        i_cpu_wdata = wdata; i_cpu_size = size;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            if (o_cpu_done) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            check_eq("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
        @(posedge i_clk); #1;
        i_cpu_write = 1'b0; i_cpu_load = 1'b0; i_cpu_size = 2'b00;
    endtask

    task automatic check_ram(input string tag, input logic [7:0] a, input logic [7:0] exp);
        check_eq(tag, 32'(ram[a]), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout got=0x0 exp=0x1");
        $fatal(1, "timeout");
    end

    initial begin
        int d1, d2, lc, ndone;
        exp_t e;
        i_rst_n = 1'b0; ram_init = 1'b1;
        i_cpu_write = 1'b0; i_cpu_load = 1'b0; i_cpu_addr = 32'h0;
        i_cpu_wdata = 32'h0; i_cpu_size = 2'b00;
        i_ld_valid = 1'b0; i_ld_addr = '0; i_ld_wdata = 8'h00;
        repeat (2) @(posedge i_clk);
        #1 ram_init = 1'b0;
        @(negedge i_clk);
        check_eq("rst_mem_addr", 32'(o_mem_addr), 32'h0);
        check_eq("rst_mem_we", 32'(o_mem_we), 32'h0);
        check_eq("rst_mem_wdata", 32'(o_mem_wdata), 32'h0);
        check_eq("rst_rdata", o_cpu_rdata, 32'h0);
        check_eq("rst_done", 32'(o_cpu_done), 32'h0);
        check_eq("rst_stall", 32'(o_cpu_stall), 32'h0);
        @(posedge i_clk); #1 i_rst_n = 1'b1;

        we_cnt = 0; done_cnt = 0;
        cpu_access(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 2'b11, 32'h0);
        check_eq("wr_we_cycles", 32'(we_cnt), 32'd4);
        check_eq("wr_done_pulses", 32'(done_cnt), 32'd1);
        check_ram("ram_10", 8'h10, 8'hEF);
        check_ram("ram_11", 8'h11, 8'hBE);
        check_ram("ram_12", 8'h12, 8'hAD);
        check_ram("ram_13", 8'h13, 8'hDE);

        cpu_access(1'b0, 1'b1, 32'h1000_0010, 32'h0, 2'b11, 32'hDEAD_BEEF);
        cpu_access(1'b0, 1'b1, 32'h0000_0012, 32'h0, 2'b10, 32'h0000_DEAD);
        cpu_access(1'b0, 1'b1, 32'h0000_0013, 32'h0, 2'b01, 32'h0000_00DE);

        cpu_access(1'b1, 1'b0, 32'h0000_00FE, 32'h1122_3344, 2'b11, 32'h0);
        check_ram("wrap_fe", 8'hFE, 8'h44);
        check_ram("wrap_ff", 8'hFF, 8'h33);
        check_ram("wrap_00", 8'h00, 8'h22);
        check_ram("wrap_01", 8'h01, 8'h11);
        cpu_access(1'b0, 1'b1, 32'h0000_00FE, 32'h0, 2'b11, 32'h1122_3344);

        we_cnt = 0;
        cpu_access(1'b0, 1'b1, 32'h0000_0080, 32'h0, 2'b00, 32'h1122_3344);
        check_eq("size0_no_we", 32'(we_cnt), 32'd0);

        // Contention straight out of reset: CPU wins the first tie, then grants alternate
        @(posedge i_clk); #1 i_rst_n = 1'b0;
        @(posedge i_clk); #1 i_rst_n = 1'b1;
        e.chk_rdata = 1'b0; e.rdata = 32'h0; e.stall = 2;
        sb_q.push_back(e);
        e.stall = 4;
        sb_q.push_back(e);
        i_cpu_write = 1'b1; i_cpu_addr = 32'h40; i_cpu_wdata = 32'h5A; i_cpu_size = 2'b01;
        i_ld_valid = 1'b1; i_ld_addr = 8'h50; i_ld_wdata = 8'h77;
        d1 = -1; d2 = -1; lc = -1; ndone = 0;
        for (int c = 0; c < 16 && ndone < 2; c++) begin
            @(negedge i_clk);
            if (ndone == 0) check_eq("ld_blocked", 32'(o_ld_ready), 32'h0);
            if (o_ld_ready && lc < 0) lc = c;
            if (o_cpu_done) begin
                ndone++;
                if (d1 < 0) d1 = c; else d2 = c;
            end
        end
        @(posedge i_clk); #1;
        i_cpu_write = 1'b0; i_cpu_size = 2'b00; i_ld_valid = 1'b0;
        check_eq("cont_cpu_done1", 32'(d1), 32'd2);
        check_eq("cont_ld_grant", 32'(lc), 32'd3);
        check_eq("cont_cpu_done2", 32'(d2), 32'd7);
        check_ram("cont_ram_40", 8'h40, 8'h5A);
        check_ram("cont_ram_50", 8'h50, 8'h77);

        // Reset after E2 of a word write leaves the first two bytes written
        @(posedge i_clk); #1;
        i_cpu_write = 1'b1; i_cpu_addr = 32'h20; i_cpu_wdata = 32'hAABB_CCDD; i_cpu_size = 2'b11;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        i_cpu_write = 1'b0; i_cpu_size = 2'b00;
        #1;
        check_eq("mid_rst_mem_addr", 32'(o_mem_addr), 32'h0);
        check_eq("mid_rst_mem_we", 32'(o_mem_we), 32'h0);
        check_eq("mid_rst_mem_wdata", 32'(o_mem_wdata), 32'h0);
        check_eq("mid_rst_rdata", o_cpu_rdata, 32'h0);
        check_eq("mid_rst_done", 32'(o_cpu_done), 32'h0);
        repeat (2) @(posedge i_clk);
        #1;
        check_ram("abort_ram_20", 8'h20, 8'hDD);
        check_ram("abort_ram_21", 8'h21, 8'hCC);
        check_ram("abort_ram_22", 8'h22, 8'h22 ^ 8'hA5);
        check_ram("abort_ram_23", 8'h23, 8'h23 ^ 8'hA5);
        i_rst_n = 1'b1;
        cpu_access(1'b0, 1'b1, 32'h0000_0021, 32'h0, 2'b01, 32'h0000_00CC);
        cpu_access(1'b0, 1'b1, 32'h0000_0020, 32'h0, 2'b10, 32'h0000_CCDD);

        repeat (2) @(posedge i_clk);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Byte-serial data-memory controller between the RV32 core's load/store port, a host byte-loader port and a single byte-wide synchronous RAM. It arbitrates the two requesters round-robin. It splits byte/half/word accesses into per-byte RAM cycles, little-endian, and stalls the core until the access completes. It sits in the board top level in place of direct multi-byte indexing of the byte memory array.

## Interface
- ADDR_W, 8, RAM byte-address width (2^ADDR_W bytes); all addresses taken modulo 2^ADDR_W
- i_clk  in  1  system clock, all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_cpu_write  in  1  core store request
- i_cpu_load  in  1  core load request
- i_cpu_addr  in  32  byte address; only [ADDR_W-1:0] used
- i_cpu_wdata  in  32  store data, byte k = [8k+7:8k]
- i_cpu_size  in  2  01 byte, 10 half, 11 word, 00 no-op
- o_cpu_rdata  out  32  load result, zero-extended, held until next load completes
- o_cpu_done  out  1  one-cycle pulse: access complete
- o_cpu_stall  out  1  combinational: (i_cpu_write | i_cpu_load) & ~o_cpu_done
- i_ld_valid  in  1  loader byte-write request
- i_ld_addr  in  ADDR_W  loader byte address
- i_ld_wdata  in  8  loader byte
- o_ld_ready  out  1  combinational: loader request accepted this cycle
- o_mem_addr  out  ADDR_W  RAM address, registered
- o_mem_we  out  1  RAM write enable, registered
- o_mem_wdata  out  8  RAM write byte, registered
- i_mem_rdata  in  8  RAM read byte, valid one cycle after address (sync read)

## Operation
- States: IDLE, CPU_WR, CPU_RD, LD_WR, DONE.
- Byte count N = 1/2/4 for size 01/10/11; byte k goes to address (addr+k) mod 2^ADDR_W.
- In IDLE, pending = CPU (write|load) and loader (i_ld_valid). One pending requester is granted. If both are pending, the one not granted last wins. last_grant resets to loader, so the CPU wins the first tie.
- CPU grant, write (write has priority if write and load are both high): go to CPU_WR and issue bytes 0..N-1 on successive cycles with o_mem_we=1, then DONE.
- CPU grant, load: go to CPU_RD and issue addresses 0..N-1 with o_mem_we=0. Capture i_mem_rdata into lane k two edges after byte k is registered. After the last byte is captured, go to DONE. Lanes >= N are cleared to 0 when the load is accepted.
- CPU grant, size 00: go straight to DONE with no RAM access; o_cpu_rdata is unchanged.
- DONE: o_cpu_done=1 for exactly one cycle, then IDLE. Nothing is accepted in DONE. The core advances at the edge ending DONE and must hold its request stable until then.
- Loader grant: o_ld_ready=1 in that IDLE cycle. Register the write byte, go to LD_WR (RAM writes at the next edge), then IDLE. Loader throughput is at most one byte per 2 cycles.
- o_mem_we is 0 in every cycle that does not carry a write byte.

## Timing
- Request sampled at edge E0; byte k registered on RAM outputs at edge Ek.
- Write: RAM updates byte k at E(k+1); DONE occupies the cycle after EN; stall is high for N+1 cycles.
- Read: byte k captured at E(k+2); DONE occupies the cycle after E(N+1); stall is high for N+2 cycles.
- Size 00: DONE occupies the cycle after E0.
- Reset (async, any state): state=IDLE, o_mem_addr=0, o_mem_we=0, o_mem_wdata=0, o_cpu_rdata=0, o_cpu_done=0, last_grant=loader. A partially completed multi-byte write is not rolled back.
- Address wrap past 2^ADDR_W-1 goes to 0 within a single access.

## Test plan
- Reset, then word write 0xDEADBEEF @0x10: RAM 0x10..0x13 = EF,BE,AD,DE. o_mem_we is high on 4 consecutive cycles, o_cpu_done pulses once after E4, and stall is high 5 cycles.
- Reads after the above:
  - Word @0x10 gives o_cpu_rdata=0xDEADBEEF, done after E5.
  - Half @0x12 gives 0x0000DEAD.
  - Byte @0x13 gives 0x000000DE.
- Wrap: word write 0x11223344 @0xFE gives 44@0xFE, 33@0xFF, 22@0x00, 11@0x01. A word read @0xFE returns 0x11223344.
- Contention: after reset, CPU byte write and loader valid asserted together. CPU is served first and o_ld_ready is 0 until the CPU's DONE. With both continuously requesting, grants alternate CPU, loader, CPU.
- Reset mid-operation: assert i_rst_n=0 after E2 of a word write 0xAABBCCDD @0x20. Only 0x20=DD and 0x21=CC are changed, all outputs read 0 immediately, and the next request is served normally.
- Size 00 with load high: done pulses in the cycle after E0, o_mem_we never rises, and o_cpu_rdata is unchanged.
